// File: rtl/alu_multicycle.sv
// ---------------------------------------------------------------------------
// alu_multicycle
//   Registered execute-stage ALU. Single-cycle logic ops, ADD/SUB with
//   signed overflow, MOV and SLT complete one cycle after an accepted start.
//   MULT (unsigned shift-add) and DIVU (unsigned restoring division) iterate
//   one step per cycle for DATA_WIDTH cycles and return a 2*DATA_WIDTH
//   Hi/Lo result.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   start        in   operation request
//   alu_op       in   [OP_WIDTH-1:0]   operation code
//   a, b         in   [DATA_WIDTH-1:0] operands
//   busy         out  MULT/DIVU iterating
//   done         out  one-cycle pulse, results valid
//   result_lo    out  [DATA_WIDTH-1:0] primary result / quotient / low product
//   result_hi    out  [DATA_WIDTH-1:0] high product / remainder, else 0
//   zero         out  result_lo == 0
//   overflow     out  signed overflow on ADD/SUB
//   div_by_zero  out  DIVU issued with b == 0
//
// Handshake: start is accepted on a rising edge only while busy=0 (FSM in
//   IDLE); operands and opcode are sampled at that edge only. done pulses
//   high for exactly one cycle when results update, and since busy=0 in
//   that cycle a new start may be accepted in the same cycle. A start seen
//   while busy=1 or while reset=1 is dropped, never queued.
// ---------------------------------------------------------------------------
module alu_multicycle #(
   parameter int DATA_WIDTH = 32,
   parameter int OP_WIDTH   = 4,
   parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [OP_WIDTH-1:0]   alu_op,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] result_lo,
   output logic [DATA_WIDTH-1:0] result_hi,
   output logic                  zero,
   output logic                  overflow,
   output logic                  div_by_zero
);

   localparam logic [OP_WIDTH-1:0] OP_AND  = OP_WIDTH'(0);
   localparam logic [OP_WIDTH-1:0] OP_OR   = OP_WIDTH'(1);
   localparam logic [OP_WIDTH-1:0] OP_NOR  = OP_WIDTH'(2);
   localparam logic [OP_WIDTH-1:0] OP_ADD  = OP_WIDTH'(3);
   localparam logic [OP_WIDTH-1:0] OP_SUB  = OP_WIDTH'(4);
   localparam logic [OP_WIDTH-1:0] OP_MULT = OP_WIDTH'(5);
   localparam logic [OP_WIDTH-1:0] OP_DIVU = OP_WIDTH'(6);
   localparam logic [OP_WIDTH-1:0] OP_MOV  = OP_WIDTH'(7);
   localparam logic [OP_WIDTH-1:0] OP_SLT  = OP_WIDTH'(8);

   localparam int MSB = DATA_WIDTH - 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MUL_RUN = 2'd1,
      DIV_RUN = 2'd2
   } state_t;

   state_t state, state_next;

   // Iteration working set, shared by MULT and DIVU:
   //   MULT: opnd = multiplicand, acc_hi = partial product, acc_lo = multiplier
   //   DIVU: opnd = divisor, acc_hi = remainder, acc_lo = dividend/quotient
   logic [DATA_WIDTH-1:0] opnd;
   logic [DATA_WIDTH-1:0] acc_hi;
   logic [DATA_WIDTH-1:0] acc_lo;
   logic [CNT_WIDTH-1:0]  cnt;

   logic accept;
   logic last_step;
   logic is_mult;
   logic is_div_iter;

   assign accept      = (state == IDLE) && start;
   assign last_step   = (cnt == CNT_WIDTH'(DATA_WIDTH - 1));
   assign is_mult     = (alu_op == OP_MULT);
   assign is_div_iter = (alu_op == OP_DIVU) && (b != '0);
   assign busy        = (state != IDLE);

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               if (is_mult)          state_next = MUL_RUN;
               else if (is_div_iter) state_next = DIV_RUN;
            end
         end
         MUL_RUN: if (last_step) state_next = IDLE;
         DIV_RUN: if (last_step) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Single-cycle result (also covers DIVU by zero)
   // ------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] sum, diff;
   logic [DATA_WIDTH-1:0] sc_lo, sc_hi;
   logic                  sc_ovf, sc_dbz;

   assign sum  = a + b;
   assign diff = a - b;

   always_comb begin
      sc_lo  = '0;
      sc_hi  = '0;
      sc_ovf = 1'b0;
      sc_dbz = 1'b0;
      case (alu_op)
         OP_AND: sc_lo = a & b;
         OP_OR:  sc_lo = a | b;
         OP_NOR: sc_lo = ~(a | b);
         OP_ADD: begin
            sc_lo  = sum;
            sc_ovf = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
         end
         OP_SUB: begin
            sc_lo  = diff;
            sc_ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
         end
         OP_DIVU: begin
            // Only reaches this path when b == 0.
            sc_lo  = '1;
            sc_hi  = a;
            sc_dbz = 1'b1;
         end
         OP_MOV: sc_lo = a;
         OP_SLT: sc_lo = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         default: ;
      endcase
   end

   // ------------------------------------------------------------------
   // Iteration steps
   // ------------------------------------------------------------------
   // Shift-add: add multiplicand if multiplier LSB set, then shift the
   // {carry, partial, multiplier} chain right by one.
   logic [DATA_WIDTH:0]   mul_sum;
   logic [DATA_WIDTH-1:0] mul_hi_n, mul_lo_n;

   assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
   assign mul_hi_n = mul_sum[DATA_WIDTH:1];
   assign mul_lo_n = {mul_sum[0], acc_lo[MSB:1]};

   // Restoring division: shift the next dividend bit into the remainder and
   // try subtracting the divisor. The remainder is always below the divisor,
   // so the W+1-bit trial is negative exactly when the subtraction fails.
   logic [DATA_WIDTH:0]   div_shift, div_trial;
   logic                  div_ge;
   logic [DATA_WIDTH-1:0] div_rem_n, div_quo_n;

   assign div_shift = {acc_hi, acc_lo[MSB]};
   assign div_trial = div_shift - {1'b0, opnd};
   assign div_ge    = ~div_trial[DATA_WIDTH];
   assign div_rem_n = div_ge ? div_trial[MSB:0] : div_shift[MSB:0];
   assign div_quo_n = {acc_lo[MSB-1:0], div_ge};

   // ------------------------------------------------------------------
   // Datapath and output registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         done        <= 1'b0;
         result_lo   <= '0;
         result_hi   <= '0;
         zero        <= 1'b0;
         overflow    <= 1'b0;
         div_by_zero <= 1'b0;
         opnd        <= '0;
         acc_hi      <= '0;
         acc_lo      <= '0;
         cnt         <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (is_mult) begin
                     opnd   <= a;
                     acc_hi <= '0;
                     acc_lo <= b;
                     cnt    <= '0;
                  end else if (is_div_iter) begin
                     opnd   <= b;
                     acc_hi <= '0;
                     acc_lo <= a;
                     cnt    <= '0;
                  end else begin
                     result_lo   <= sc_lo;
                     result_hi   <= sc_hi;
                     zero        <= (sc_lo == '0);
                     overflow    <= sc_ovf;
                     div_by_zero <= sc_dbz;
                     done        <= 1'b1;
                  end
               end
            end
            MUL_RUN: begin
               acc_hi <= mul_hi_n;
               acc_lo <= mul_lo_n;
               cnt    <= cnt + CNT_WIDTH'(1);
               if (last_step) begin
                  result_lo   <= mul_lo_n;
                  result_hi   <= mul_hi_n;
                  zero        <= (mul_lo_n == '0);
                  overflow    <= 1'b0;
                  div_by_zero <= 1'b0;
                  done        <= 1'b1;
               end
            end
            DIV_RUN: begin
               acc_hi <= div_rem_n;
               acc_lo <= div_quo_n;
               cnt    <= cnt + CNT_WIDTH'(1);
               if (last_step) begin
                  result_lo   <= div_quo_n;
                  result_hi   <= div_rem_n;
                  zero        <= (div_quo_n == '0);
                  overflow    <= 1'b0;
                  div_by_zero <= 1'b0;
                  done        <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_multicycle.sv
// ---------------------------------------------------------------------------
// tb_alu_multicycle
//   Directed and randomized checks of alu_multicycle against a plain
//   arithmetic reference model. Expected results are queued at issue time;
//   a monitor pops and compares on every done pulse.
// ---------------------------------------------------------------------------
module tb_alu_multicycle;

   localparam int W = 32;

   localparam logic [3:0] OP_AND  = 4'd0;
   localparam logic [3:0] OP_OR   = 4'd1;
   localparam logic [3:0] OP_ADD  = 4'd3;
   localparam logic [3:0] OP_SUB  = 4'd4;
   localparam logic [3:0] OP_MULT = 4'd5;
   localparam logic [3:0] OP_DIVU = 4'd6;
   localparam logic [3:0] OP_SLT  = 4'd8;

   // ------------------------------------------------------------------
   // Clock / reset
   // ------------------------------------------------------------------
   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [3:0]   alu_op;
   logic [W-1:0] a, b;
   logic         busy, done;
   logic [W-1:0] result_lo, result_hi;
   logic         zero, overflow, div_by_zero;

   always #5 clk = ~clk;

   alu_multicycle dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .alu_op      (alu_op),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .result_lo   (result_lo),
      .result_hi   (result_hi),
      .zero        (zero),
      .overflow    (overflow),
      .div_by_zero (div_by_zero)
   );

   // ------------------------------------------------------------------
   // Scoreboard
   // ------------------------------------------------------------------
   // Packed expectation: {hi[66:35], lo[34:3], zero[2], ovf[1], dbz[0]}
   logic [2*W+2:0] exp_q[$];
   int tests  = 0;
   int failed = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: straight arithmetic on the operation definitions.
   function automatic logic [2*W+2:0] ref_model(input logic [3:0] op, input logic [W-1:0] x,
                                                 input logic [W-1:0] y);
      logic [W-1:0] lo, hi;
      logic         ovf, dbz;
      logic [63:0]  prod;
      int           sx, sy;
      longint       wide;
      lo = '0; hi = '0; ovf = 1'b0; dbz = 1'b0;
      sx = x; sy = y;
      case (op)
         4'd0: lo = x & y;
         4'd1: lo = x | y;
         4'd2: lo = ~(x | y);
         4'd3: begin
            lo   = x + y;
            wide = longint'(sx) + longint'(sy);
            ovf  = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
         end
         4'd4: begin
            lo   = x - y;
            wide = longint'(sx) - longint'(sy);
            ovf  = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
         end
         4'd5: begin
            prod = 64'(x) * 64'(y);
            lo   = prod[31:0];
            hi   = prod[63:32];
         end
         4'd6: begin
            if (y == 0) begin
               lo = 32'hFFFF_FFFF; hi = x; dbz = 1'b1;
            end else begin
               lo = x / y; hi = x % y;
            end
         end
         4'd7: lo = x;
         4'd8: lo = (sx < sy) ? 32'd1 : 32'd0;
         default: ;
      endcase
      return {hi, lo, (lo == 0), ovf, dbz};
   endfunction

   // Monitor: every done pulse must match the oldest outstanding request.
   always @(negedge clk) begin
      logic [2*W+2:0] e;
      if (done) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 64'(done), 64'd0);
         end else begin
            e = exp_q.pop_front();
            check("result_lo",   64'(result_lo),   64'(e[34:3]));
            check("result_hi",   64'(result_hi),   64'(e[66:35]));
            check("zero",        64'(zero),        64'(e[2]));
            check("overflow",    64'(overflow),    64'(e[1]));
            check("div_by_zero", 64'(div_by_zero), 64'(e[0]));
         end
      end
   end

   // ------------------------------------------------------------------
   // Driver tasks
   // ------------------------------------------------------------------
   // Present a request in the current (negedge) time slot.
   task automatic launch(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
      exp_q.push_back(ref_model(op, x, y));
      start  = 1'b1;
      alu_op = op;
      a      = x;
      b      = y;
   endtask

   // Wait for done, scrambling inputs after acceptance; optionally inject an
   // ADD start (which must be ignored) while busy. Checks latency and busy.
   task automatic wait_done(input int exp_lat, input int exp_busy, input int inject_at);
      int lat = 0;
      int busy_cnt = 0;
      do begin
         @(negedge clk);
         lat++;
         if (busy) busy_cnt++;
         start  = (lat == inject_at);
         alu_op = (lat == inject_at) ? OP_ADD : 4'($urandom_range(0, 15));
         a      = $urandom;
         b      = $urandom;
      end while (!done && lat < 200);
      start = 1'b0;
      check("latency",     64'(lat),      64'(exp_lat));
      check("busy_cycles", 64'(busy_cnt), 64'(exp_busy));
   endtask

   task automatic run_op(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                         input int inject_at);
      bit iter;
      iter = (op == OP_MULT) || (op == OP_DIVU && y != 0);
      @(negedge clk);
      launch(op, x, y);
      wait_done(iter ? W + 1 : 1, iter ? W : 0, inject_at);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_done"}, 64'(done), 64'd0);
      check({tag, "_lo"},   64'(result_lo), 64'd0);
      check({tag, "_hi"},   64'(result_hi), 64'd0);
      check({tag, "_zero"}, 64'(zero), 64'd0);
      check({tag, "_ovf"},  64'(overflow), 64'd0);
      check({tag, "_dbz"},  64'(div_by_zero), 64'd0);
   endtask

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   initial begin
      int done_seen;
      logic [3:0]   rop;
      logic [W-1:0] ra, rb;

      reset = 1'b1; start = 1'b0; alu_op = '0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      reset = 1'b0;

      // Directed cases
      run_op(OP_ADD,  32'h7FFF_FFFF, 32'd1, -1);
      run_op(OP_SUB,  32'd5, 32'd5, -1);
      run_op(OP_SLT,  32'hFFFF_FFFF, 32'd1, -1);
      run_op(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
      run_op(OP_DIVU, 32'd100, 32'd7, 12);
      run_op(OP_DIVU, 32'd9, 32'd0, -1);
      run_op(OP_SUB,  32'h8000_0000, 32'd1, -1);
      run_op(OP_ADD,  32'h8000_0000, 32'h8000_0000, -1);
      run_op(4'd13,   32'h1234_5678, 32'h9ABC_DEF0, -1);

      // Reset ten cycles into a MULT; a start during reset must be dropped.
      @(negedge clk);
      launch(OP_MULT, 32'hDEAD_BEEF, 32'h0000_1234);
      repeat (10) begin
         @(negedge clk);
         start = 1'b0;
      end
      exp_q.delete();
      reset  = 1'b1;
      start  = 1'b1;
      alu_op = OP_ADD;
      a      = 32'd1;
      b      = 32'd1;
      @(negedge clk);
      check_all_zero("midreset");
      reset = 1'b0;
      start = 1'b0;
      done_seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) done_seen++;
      end
      check("no_done_after_reset", 64'(done_seen), 64'd0);

      run_op(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, -1);

      // Back-to-back: new start in the MULT done cycle.
      run_op(OP_MULT, 32'd12345, 32'd6789, -1);
      launch(OP_OR, 32'd1, 32'd2);
      wait_done(1, 0, -1);

      // Randomized
      for (int i = 0; i < 60; i++) begin
         rop = 4'($urandom_range(0, 15));
         if (i % 4 == 0) rop = OP_MULT;
         if (i % 4 == 1) rop = OP_DIVU;
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 5))
            0: rb = 32'($urandom_range(0, 3));
            1: ra = 32'($urandom_range(0, 15));
            2: rb = ra;
            default: ;
         endcase
         run_op(rop, ra, rb, (i % 3 == 0) ? 7 : -1);
      end

      repeat (3) @(negedge clk);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Parametrised, registered successor to the single-cycle datapath ALU.
- Adds iterative unsigned multiply and divide with a 2*DATA_WIDTH Hi/Lo result, signed overflow detection, SLT, and a start/busy/done handshake.
- Sits in the execute stage and stalls the pipeline through `busy` while a MULT or DIVU is in flight.
- Operand and opcode inputs are sampled only on an accepted start.

Parameters:
- DATA_WIDTH, 32, operand and result_lo width; must be >= 4 and even.
- OP_WIDTH, 4, ALU operation code width.
- CNT_WIDTH, $clog2(DATA_WIDTH)+1, iteration counter width; the default must not be overridden.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous active-high reset.
- start  input  1  request; accepted only while busy=0.
- alu_op  input  OP_WIDTH  operation code.
- a  input  DATA_WIDTH  operand A.
- b  input  DATA_WIDTH  operand B.
- busy  output  1  high while a MULT or DIVU is iterating.
- done  output  1  one-cycle pulse: result valid.
- result_lo  output  DATA_WIDTH  primary result, or quotient / low product.
- result_hi  output  DATA_WIDTH  high product or remainder; 0 for other ops.
- zero  output  1  result_lo == 0.
- overflow  output  1  signed overflow on ADD/SUB; 0 otherwise.
- div_by_zero  output  1  DIVU issued with b == 0.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values: on reset, busy, done, result_lo, result_hi, zero, overflow and div_by_zero all go to 0 and the FSM returns to IDLE.
  - Reset mid-operation aborts the operation with no done pulse.
  - A start asserted in the same cycle as reset is ignored.
- Opcode map:
  - AND=0000, OR=0001, NOR=0010, ADD=0011, SUB=0100 (two's complement, modulo 2^W).
  - MULT=0101 (unsigned, W x W -> 2W).
  - DIVU=0110 (unsigned quotient/remainder).
  - MOV=0111 (result_lo=a).
  - SLT=1000 (result_lo=1 if signed a<b, else 0).
  - All other codes: result_lo=0, result_hi=0, done still pulses.
- FSM states: IDLE, MUL_RUN, DIV_RUN.
  - IDLE + start + single-cycle op: result registered at that edge; done=1 for the next cycle only; stays IDLE. Latency 1.
  - IDLE + start + MULT: latch a and b; busy=1; enter MUL_RUN with count=0.
    - One shift-add step per cycle.
    - After DATA_WIDTH steps: write {result_hi,result_lo}, done=1, busy=0, return to IDLE.
    - done is high in cycle start+DATA_WIDTH+1.
  - IDLE + start + DIVU, b!=0: enter DIV_RUN and run one restoring-division step per cycle, same timing as MULT.
  - IDLE + start + DIVU, b==0: no iteration. result_lo = all ones, result_hi = a, div_by_zero=1, done next cycle. Latency 1.
- Handshake:
  - start while busy=1 is ignored; no queueing.
  - done and a new start may coincide in the same cycle. Because busy=0 in that cycle, the start is accepted.
  - a, b and alu_op may change freely after the accepting edge.
- Output holding:
  - Result outputs and flags hold their last values until the next completion; they update only at completion.
  - zero is computed from the final result_lo. overflow and div_by_zero are cleared on every completion unless set by that operation.
- Overflow rule: ADD sets overflow when sign(a)==sign(b) and sign(sum)!=sign(a). SUB sets it when sign(a)!=sign(b) and sign(diff)!=sign(a).
- Single-cycle ops never assert busy.

Test Plan:
- ADD a=32'h7FFF_FFFF, b=1, one-cycle start -> next cycle: done=1, result_lo=32'h8000_0000, overflow=1, zero=0, busy never high.
- SUB a=5, b=5 -> done next cycle: result_lo=0, zero=1, overflow=0. Then SLT a=32'hFFFF_FFFF, b=1 -> result_lo=1.
- MULT a=32'hFFFF_FFFF, b=32'hFFFF_FFFF:
  - busy is high for 32 cycles; a second start during busy (ADD) is ignored.
  - done in cycle start+33 with result_hi=32'hFFFF_FFFE, result_lo=32'h0000_0001.
- DIVU a=100, b=7 -> done at start+33 with result_lo=14, result_hi=2, div_by_zero=0. Then DIVU a=9, b=0 -> done next cycle: result_lo=32'hFFFF_FFFF, result_hi=9, div_by_zero=1.
- Reset asserted at cycle 10 of a MULT -> next cycle all outputs are 0, busy=0, and no done pulse follows. A new AND a=32'hF0F0_F0F0, b=32'hFF00_FF00 then completes with result_lo=32'hF000_F000.
- Back-to-back: a new start in the same cycle as the MULT done pulse (OR a=1, b=2) is accepted, and result_lo=3 appears the following cycle.
